// File: rtl/memory_layer_node_count_reader_pkg.sv
// Shared constants, types and FSM encoding for the memory-layer node-count reader.
package memory_layer_node_count_reader_pkg;

    localparam int NUM_CLASSES = 16;
    localparam int COUNT_W     = 16;
    localparam int CLS_W       = $clog2(NUM_CLASSES);
    localparam int TOTAL_W     = COUNT_W + CLS_W;

    typedef logic [CLS_W-1:0]   class_idx_t;
    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [TOTAL_W-1:0] total_t;

    typedef count_t node_counter_mem_T [NUM_CLASSES];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RSP,
        ST_SCAN
    } rd_state_e;

endpackage

// File: rtl/memory_layer_scan_accum.sv
// Running sum plus argmax over a stream of per-class counts; lowest index wins ties.
// Combinational next-values let the caller capture the final result on the last step.
module memory_layer_scan_accum
    import memory_layer_node_count_reader_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int IDX_W = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   step,
    input  logic [IDX_W-1:0]       idx,
    input  logic [CNT_W-1:0]       value,
    output logic [CNT_W+IDX_W-1:0] sum_nxt,
    output logic [IDX_W-1:0]       max_idx_nxt
);

    logic [CNT_W+IDX_W-1:0] sum_q;
    logic [CNT_W-1:0]       max_val_q;
    logic [IDX_W-1:0]       max_idx_q;
    logic                   take;

    // Strict compare keeps the earlier (lower) index on equal counts.
    always_comb begin
        take        = value > max_val_q;
        sum_nxt     = sum_q + (CNT_W+IDX_W)'(value);
        max_idx_nxt = take ? idx : max_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum_q     <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else if (step) begin
            sum_q     <= sum_nxt;
            max_idx_q <= max_idx_nxt;
            if (take) max_val_q <= value;
        end
    end

endmodule

// File: rtl/memory_layer_node_count_reader.sv
// Per-class node-count table with saturating increments, a valid/ready count query
// port and a one-class-per-cycle scan returning total and most-populated class.
module memory_layer_node_count_reader
    import memory_layer_node_count_reader_pkg::*;
#(
    parameter int NUM_CLASSES = memory_layer_node_count_reader_pkg::NUM_CLASSES,
    parameter int COUNT_W     = memory_layer_node_count_reader_pkg::COUNT_W,
    localparam int IDX_W      = $clog2(NUM_CLASSES),
    localparam int SUM_W      = COUNT_W + IDX_W
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_valid,
    input  logic [IDX_W-1:0]   inc_class,
    input  logic               clr,
    input  logic               rd_req_valid,
    output logic               rd_req_ready,
    input  logic [IDX_W-1:0]   rd_class,
    output logic               rd_rsp_valid,
    input  logic               rd_rsp_ready,
    output logic [COUNT_W-1:0] rd_count,
    input  logic               scan_start,
    output logic               scan_busy,
    output logic               scan_done,
    output logic [SUM_W-1:0]   scan_total,
    output logic [IDX_W-1:0]   scan_max_class
);

    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [COUNT_W-1:0] table_q [NUM_CLASSES];
    rd_state_e          state_q, state_nxt;
    logic [IDX_W-1:0]   idx_q;
    logic [COUNT_W-1:0] rd_count_q;
    logic               scan_done_q;
    logic [SUM_W-1:0]   scan_total_q;
    logic [IDX_W-1:0]   scan_max_q;
    logic               req_fire, scan_go, scan_last;
    logic [COUNT_W-1:0] rd_val;
    logic [SUM_W-1:0]   acc_sum_nxt;
    logic [IDX_W-1:0]   acc_max_nxt;
    logic               inc_ok, rd_ok;

    assign inc_ok = {1'b0, inc_class} < NUM_EXT;
    assign rd_ok  = {1'b0, rd_class} < NUM_EXT;
    assign rd_val = rd_ok ? table_q[rd_class] : '0;

    // clr beats a same-cycle increment; increments never stall.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NUM_CLASSES; i++) table_q[i] <= '0;
        end else if (inc_valid && inc_ok && (table_q[inc_class] != '1)) begin
            table_q[inc_class] <= table_q[inc_class] + COUNT_W'(1);
        end
    end

    always_comb begin
        state_nxt    = state_q;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        scan_busy    = 1'b0;
        req_fire     = 1'b0;
        scan_go      = 1'b0;
        scan_last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rd_req_ready = 1'b1;
                if (rd_req_valid) begin
                    req_fire  = 1'b1;
                    state_nxt = ST_RSP;
                end else if (scan_start) begin
                    scan_go   = 1'b1;
                    state_nxt = ST_SCAN;
                end
            end
            ST_RSP: begin
                rd_rsp_valid = 1'b1;
                if (rd_rsp_ready) state_nxt = ST_IDLE;
            end
            ST_SCAN: begin
                scan_busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    scan_last = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rd_count_q   <= '0;
            scan_done_q  <= 1'b0;
            scan_total_q <= '0;
            scan_max_q   <= '0;
        end else begin
            state_q     <= state_nxt;
            scan_done_q <= scan_last;
            if (scan_go) idx_q <= '0;
            else if (scan_busy) idx_q <= idx_q + IDX_W'(1);
            if (req_fire) rd_count_q <= rd_val;
            if (scan_last) begin
                scan_total_q <= acc_sum_nxt;
                scan_max_q   <= acc_max_nxt;
            end
        end
    end

    memory_layer_scan_accum #(
        .CNT_W (COUNT_W),
        .IDX_W (IDX_W)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear       (scan_go),
        .step        (scan_busy),
        .idx         (idx_q),
        .value       (table_q[idx_q]),
        .sum_nxt     (acc_sum_nxt),
        .max_idx_nxt (acc_max_nxt)
    );

    assign rd_count       = rd_count_q;
    assign scan_done      = scan_done_q;
    assign scan_total     = scan_total_q;
    assign scan_max_class = scan_max_q;

endmodule

// File: tb/tb_memory_layer_node_count_reader.sv
// Bench for memory_layer_node_count_reader: vector table of increment/read pairs,
// a response scoreboard queue, and hand sequences for scan, reset and clear corners.
module tb_memory_layer_node_count_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        inc_valid, clr, rd_req_valid, rd_rsp_ready, scan_start;
    logic [3:0]  inc_class, rd_class;
    logic        rd_req_ready, rd_rsp_valid, scan_busy, scan_done;
    logic [15:0] rd_count;
    logic [19:0] scan_total;
    logic [3:0]  scan_max_class;

    logic        s_inc_valid, s_rd_req_valid, s_rd_rsp_ready;
    logic [3:0]  s_inc_class, s_rd_class;
    logic        s_rd_req_ready, s_rd_rsp_valid, s_scan_busy, s_scan_done;
    logic [3:0]  s_rd_count;
    logic [7:0]  s_scan_total;
    logic [3:0]  s_scan_max_class;

    always #5 clk = ~clk;

    memory_layer_node_count_reader u_dut (
        .clk(clk), .rst(rst), .inc_valid(inc_valid), .inc_class(inc_class), .clr(clr),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_class(rd_class),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_count(rd_count),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
        .scan_total(scan_total), .scan_max_class(scan_max_class)
    );

    memory_layer_node_count_reader #(.NUM_CLASSES(16), .COUNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .inc_valid(s_inc_valid), .inc_class(s_inc_class), .clr(1'b0),
        .rd_req_valid(s_rd_req_valid), .rd_req_ready(s_rd_req_ready), .rd_class(s_rd_class),
        .rd_rsp_valid(s_rd_rsp_valid), .rd_rsp_ready(s_rd_rsp_ready), .rd_count(s_rd_count),
        .scan_start(1'b0), .scan_busy(s_scan_busy), .scan_done(s_scan_done),
        .scan_total(s_scan_total), .scan_max_class(s_scan_max_class)
    );

    typedef struct {
        int cls;
        int incs;
        int exp;
    } vec_t;

    vec_t vecs [6];
    int   exp_q [$];
    int   tests = 0;
    int   fails = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic inc_n(input int cls, input int n);
        for (int i = 0; i < n; i++) begin
            inc_valid = 1'b1;
            inc_class = cls[3:0];
            step();
        end
        inc_valid = 1'b0;
    endtask

    task automatic do_read(input int cls, input int exp, input string name);
        int t;
        t = 0;
        while (rd_req_ready !== 1'b1 && t < 50) begin step(); t++; end
        check({name, "_req_rdy"}, rd_req_ready, 1);
        rd_req_valid = 1'b1;
        rd_class     = cls[3:0];
        exp_q.push_back(exp);
        step();
        rd_req_valid = 1'b0;
        t = 0;
        while (rd_rsp_valid !== 1'b1 && t < 50) begin step(); t++; end
        check({name, "_rsp_vld"}, rd_rsp_valid, 1);
        check(name, rd_count, exp_q.pop_front());
        rd_rsp_ready = 1'b1;
        step();
        rd_rsp_ready = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  ev;

        vecs[0] = '{5, 3, 3};
        vecs[1] = '{0, 0, 0};
        vecs[2] = '{2, 7, 7};
        vecs[3] = '{9, 1, 1};
        vecs[4] = '{5, 2, 5};
        vecs[5] = '{15, 4, 4};

        rst = 1'b1; inc_valid = 1'b0; inc_class = '0; clr = 1'b0;
        rd_req_valid = 1'b0; rd_class = '0; rd_rsp_ready = 1'b0; scan_start = 1'b0;
        s_inc_valid = 1'b0; s_inc_class = '0; s_rd_req_valid = 1'b0; s_rd_class = '0;
        s_rd_rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_req_ready", rd_req_ready, 1);
        check("rst_rsp_valid", rd_rsp_valid, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_scan_busy", scan_busy, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_scan_total", scan_total, 0);
        check("rst_scan_max", scan_max_class, 0);

        foreach (vecs[i]) begin
            inc_n(vecs[i].cls, vecs[i].incs);
            do_read(vecs[i].cls, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Response held off for four cycles must stay stable and block new requests.
        exp_q.push_back(5);
        rd_req_valid = 1'b1; rd_class = 4'd5;
        step();
        rd_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("hold%0d_vld", k), rd_rsp_valid, 1);
            check($sformatf("hold%0d_cnt", k), rd_count, exp_q[0]);
            check($sformatf("hold%0d_rdy", k), rd_req_ready, 0);
            step();
        end
        rd_rsp_ready = 1'b1;
        check("hold_release_cnt", rd_count, exp_q.pop_front());
        step();
        rd_rsp_ready = 1'b0;
        check("hold_return_rdy", rd_req_ready, 1);
        check("hold_return_vld", rd_rsp_valid, 0);

        // Read snapshot precedes a same-cycle increment of the same class.
        exp_q.push_back(7);
        rd_req_valid = 1'b1; rd_class = 4'd2; inc_valid = 1'b1; inc_class = 4'd2;
        step();
        rd_req_valid = 1'b0; inc_valid = 1'b0;
        check("snap_vld", rd_rsp_valid, 1);
        check("snap_cnt", rd_count, exp_q.pop_front());
        rd_rsp_ready = 1'b1;
        step();
        rd_rsp_ready = 1'b0;
        do_read(2, 8, "snap_next");

        // Scan over {c0=2, c3=9, c7=9}, with a request held pending throughout.
        rst = 1'b1; step(); rst = 1'b0;
        inc_n(0, 2);
        inc_n(3, 9);
        inc_n(7, 9);
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        rd_req_valid = 1'b1; rd_class = 4'd3;
        check("scan_busy_first", scan_busy, 1);
        check("scan_req_refused", rd_req_ready, 0);
        cyc = 1; seen = 0;
        while (scan_done !== 1'b1 && cyc < 40) begin
            if (rd_rsp_valid === 1'b1) seen = 1;
            step();
            cyc++;
        end
        rd_req_valid = 1'b0;
        check("scan_latency", cyc, 17);
        check("scan_total", scan_total, 20);
        check("scan_max", scan_max_class, 3);
        check("scan_no_rsp", seen, 0);
        check("scan_busy_done", scan_busy, 0);
        step();
        check("scan_done_pulse", scan_done, 0);
        check("scan_total_hold", scan_total, 20);

        // Request and scan_start together: request is served, scan is dropped.
        exp_q.push_back(2);
        rd_req_valid = 1'b1; rd_class = 4'd0; scan_start = 1'b1;
        step();
        rd_req_valid = 1'b0; scan_start = 1'b0;
        check("tie_busy", scan_busy, 0);
        check("tie_vld", rd_rsp_valid, 1);
        check("tie_cnt", rd_count, exp_q.pop_front());
        rd_rsp_ready = 1'b1;
        step();
        rd_rsp_ready = 1'b0;
        ev = 0;
        for (int k = 0; k < 20; k++) begin
            if (scan_done === 1'b1 || scan_busy === 1'b1) ev++;
            step();
        end
        check("tie_scan_dropped", ev, 0);

        // Reset while the scan is visiting class 6.
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        repeat (6) step();
        check("midscan_busy", scan_busy, 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_busy", scan_busy, 0);
        check("midrst_req_rdy", rd_req_ready, 1);
        check("midrst_rsp_vld", rd_rsp_valid, 0);
        check("midrst_rd_count", rd_count, 0);
        check("midrst_total", scan_total, 0);
        check("midrst_max", scan_max_class, 0);
        ev = 0;
        for (int k = 0; k < 25; k++) begin
            if (scan_done === 1'b1) ev++;
            step();
        end
        check("midrst_no_done", ev, 0);
        do_read(3, 0, "midrst_table");

        // Clear beats a same-cycle increment.
        inc_n(4, 3);
        do_read(4, 3, "pre_clr");
        clr = 1'b1; inc_valid = 1'b1; inc_class = 4'd4;
        step();
        clr = 1'b0; inc_valid = 1'b0;
        do_read(4, 0, "clr_wins");
        inc_n(4, 1);
        do_read(4, 1, "post_clr");

        // Saturation on the narrow-count instance.
        for (int k = 0; k < 20; k++) begin
            s_inc_valid = 1'b1; s_inc_class = 4'd1;
            step();
        end
        s_inc_valid = 1'b0;
        check("sat_req_rdy", s_rd_req_ready, 1);
        exp_q.push_back(15);
        s_rd_req_valid = 1'b1; s_rd_class = 4'd1;
        step();
        s_rd_req_valid = 1'b0;
        check("sat_vld", s_rd_rsp_valid, 1);
        check("sat_cnt", s_rd_count, exp_q.pop_front());
        s_rd_rsp_ready = 1'b1;
        step();
        s_rd_rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
